alu_req_arbiter: RTL and testbench

//  Round-robin arbiter that lets NUM_REQ command sources share the single FIFO_IN write port of the ALU.

---
 rtl/alu_req_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ command sources into the single FIFO_IN write port.
// Each accepted word is tagged with its source index in the ID MSBs and charged against a per-source credit.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned FIFO_IN_WIDTH = 42,
    parameter int unsigned ID_LSB        = 2,
    parameter int unsigned ID_SIZE       = 8,
    parameter int unsigned MAX_OUTST     = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*FIFO_IN_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               rsp_done,
    input  logic                             fifo_full,
    output logic                             fifo_w_en,
    output logic [FIFO_IN_WIDTH-1:0]         fifo_wdata,
    output logic [NUM_REQ*CNT_W-1:0]         outstanding,
    output logic                             busy,
    output logic                             err_underflow
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned TAG_MSB = ID_LSB + ID_SIZE - 1;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t                     state_q, state_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]           win_q, win_d;
    logic [FIFO_IN_WIDTH-1:0]   hold_q, hold_d;
    logic [NUM_REQ*CNT_W-1:0]   outst_q, outst_d;
    logic                       err_q, err_d;

    logic [NUM_REQ-1:0]         eligible;
    logic                       any_elig;
    logic [PTR_W-1:0]           arb_win;
    logic [PTR_W-1:0]           scan_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (outst_q[i*CNT_W +: CNT_W] < CNT_W'(MAX_OUTST));
        end
    end

    // Scan upward from rr_ptr; NUM_REQ is a power of two so the index wraps by truncation.
    always_comb begin
        any_elig = 1'b0;
        arb_win  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr_q + PTR_W'(k);
            if (!any_elig && eligible[scan_idx]) begin
                any_elig = 1'b1;
                arb_win  = scan_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        hold_d    = hold_q;
        req_ready = '0;
        fifo_w_en = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    req_ready[arb_win]    = 1'b1;
                    win_d                 = arb_win;
                    hold_d                = req_data[int'(arb_win)*FIFO_IN_WIDTH +: FIFO_IN_WIDTH];
                    hold_d[TAG_MSB -: PTR_W] = arb_win;
                    state_d               = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                fifo_w_en = !fifo_full;
                if (!fifo_full) begin
                    rr_ptr_d = win_q + PTR_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credits are charged at accept; a simultaneous accept and completion cancel out.
    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && !rsp_done[i]) begin
                outst_d[i*CNT_W +: CNT_W] = outst_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end else if (!req_ready[i] && rsp_done[i]) begin
                if (outst_q[i*CNT_W +: CNT_W] == '0) begin
                    err_d = 1'b1;
                end else begin
                    outst_d[i*CNT_W +: CNT_W] = outst_q[i*CNT_W +: CNT_W] - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            hold_q   <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

    assign fifo_wdata    = hold_q;
    assign outstanding   = outst_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: expected FIFO words are queued when commands are offered
// and popped by a write monitor; control outputs are checked inline.
module tb_alu_req_arbiter;

    localparam int W       = 42;
    localparam int TAG_BIT = 2 + 8 - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [2*W-1:0] req_data;
    logic [1:0]     req_ready;
    logic [1:0]     rsp_done;
    logic           fifo_full;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_wdata;
    logic [5:0]     outstanding;
    logic           busy;
    logic           err_underflow;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] sb[$];

    localparam logic [W-1:0] W0 = W'(48'h0AAAA55553F1);
    localparam logic [W-1:0] W1 = W'(48'h0123456789AB);
    localparam logic [W-1:0] W2 = W'(48'h00F0F0F0F0F0);
    localparam logic [W-1:0] W3 = W'(48'h03FFFFFFFFFF);

    alu_req_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_done      (rsp_done),
        .fifo_full     (fifo_full),
        .fifo_w_en     (fifo_w_en),
        .fifo_wdata    (fifo_wdata),
        .outstanding   (outstanding),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] tag(input logic [W-1:0] w, input int idx);
        logic [W-1:0] r;
        r = w;
        r[TAG_BIT] = idx[0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2ns later, well away from posedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    always @(negedge clk) begin
        #2;
        if (fifo_w_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_write", 64'(fifo_wdata), 64'hDEAD);
            end else begin
                check("fifo_wdata", 64'(fifo_wdata), 64'(sb.pop_front()));
            end
        end
    end

    // One grant for requester idx from IDLE, then its push cycle with fifo not full.
    task automatic grant_and_push(input int idx, input logic [W-1:0] word, input bit drop_after);
        settle();
        check("req_ready", 64'(req_ready), 64'(2'b01 << idx));
        sb.push_back(tag(word, idx));
        step();
        if (drop_after) req_valid[idx] = 1'b0;
        settle();
        check("push_w_en", 64'(fifo_w_en), 64'd1);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_done  = '0;
        fifo_full = 1'b0;

        // Reset state
        settle();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_w_en", 64'(fifo_w_en), 64'd0);
        check("rst_wdata", 64'(fifo_wdata), 64'd0);
        check("rst_outst", 64'(outstanding), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            settle();
            check("idle_w_en", 64'(fifo_w_en), 64'd0);
        end

        // Single command from requester 0; ID MSB tagged to 0
        step();
        req_valid = 2'b01;
        req_data[0 +: W] = W0;
        settle();
        check("t2_ready", 64'(req_ready), 64'd1);
        sb.push_back(tag(W0, 0));
        step();
        req_valid = 2'b00;
        settle();
        check("t2_w_en", 64'(fifo_w_en), 64'd1);
        check("t2_busy", 64'(busy), 64'd1);
        check("t2_outst", 64'(outstanding), 64'(6'b000_001));
        step();
        settle();
        check("t2_after_w_en", 64'(fifo_w_en), 64'd0);
        check("t2_after_busy", 64'(busy), 64'd0);
        rsp_done = 2'b01;
        step();
        rsp_done = 2'b00;
        settle();
        check("t2_released", 64'(outstanding), 64'd0);

        // Both valid: rr_ptr is now 1, so grants alternate 1,0,1,0
        req_valid = 2'b11;
        req_data  = {W1, W0};
        grant_and_push(1, W1, 1'b0);
        grant_and_push(0, W0, 1'b0);
        grant_and_push(1, W1, 1'b0);
        grant_and_push(0, W0, 1'b1);
        req_valid = 2'b00;
        settle();
        check("t3_outst", 64'(outstanding), 64'(6'b010_010));
        rsp_done = 2'b11;
        step();
        step();
        rsp_done = 2'b00;
        settle();
        check("t3_released", 64'(outstanding), 64'd0);

        // FIFO full for 5 cycles in WRITE: no write, data held, then exactly one push
        req_valid = 2'b10;
        fifo_full = 1'b1;
        settle();
        check("t4_ready", 64'(req_ready), 64'b10);
        sb.push_back(tag(W1, 1));
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t4_full_w_en", 64'(fifo_w_en), 64'd0);
            check("t4_full_data", 64'(fifo_wdata), 64'(tag(W1, 1)));
            step();
        end
        fifo_full = 1'b0;
        settle();
        check("t4_push", 64'(fifo_w_en), 64'd1);
        step();
        settle();
        check("t4_no_dup", 64'(fifo_w_en), 64'd0);

        // Requester 0 fills its credits; requester 1 still served; rsp_done frees req0
        req_valid = 2'b01;
        req_data  = {W3, W2};
        for (int i = 0; i < 4; i++) grant_and_push(0, W2, 1'b0);
        settle();
        check("t5_limit_ready", 64'(req_ready), 64'd0);
        check("t5_limit_busy", 64'(busy), 64'd0);
        check("t5_outst", 64'(outstanding), 64'(6'b001_100));
        req_valid = 2'b11;
        grant_and_push(1, W3, 1'b1);
        settle();
        check("t5_still_blocked", 64'(req_ready), 64'd0);
        rsp_done = 2'b01;
        step();
        rsp_done = 2'b00;
        grant_and_push(0, W2, 1'b1);
        settle();
        check("t5_outst2", 64'(outstanding), 64'(6'b010_100));

        // Underflow on requester 1, sticky; simultaneous accept+done keeps count
        rsp_done = 2'b10;
        step();
        step();
        settle();
        check("t6_no_err_yet", 64'(err_underflow), 64'd0);
        step();
        rsp_done = 2'b00;
        settle();
        check("t6_err", 64'(err_underflow), 64'd1);
        check("t6_cnt_zero", 64'(outstanding), 64'(6'b000_100));
        step();
        step();
        settle();
        check("t6_sticky", 64'(err_underflow), 64'd1);
        rsp_done = 2'b01;
        step();
        rsp_done  = 2'b01;
        req_valid = 2'b01;
        settle();
        check("t6_ready", 64'(req_ready), 64'd1);
        sb.push_back(tag(W2, 0));
        step();
        rsp_done  = 2'b00;
        req_valid = 2'b00;
        settle();
        check("t6_same_cnt", 64'(outstanding), 64'(6'b000_011));
        step();

        // Reset while WRITE is stalled: command dropped, credit cleared, no write
        fifo_full = 1'b1;
        req_valid = 2'b10;
        settle();
        check("t7_ready", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b00;
        settle();
        check("t7_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        settle();
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_outst", 64'(outstanding), 64'd0);
        check("t7_rst_err", 64'(err_underflow), 64'd0);
        step();
        fifo_full = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            check("t7_no_write", 64'(fifo_w_en), 64'd0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
